// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: handshake and status bundle for the 3x3 window controller.
//   start       frame start request (single-cycle pulse), driven by master
//   in_valid    upstream pixel available, driven by master
//   in_ready    controller accepts a pixel this cycle, driven by slave
//   lb_wr_en    line-buffer write/shift strobe (equals accept), driven by slave
//   lb_addr     line-buffer column address (current column), driven by slave
//   out_valid   3x3 window complete, driven by slave
//   out_ready   downstream consumes window, driven by master
//   out_row     window centre row, driven by slave
//   out_col     window centre column, driven by slave
//   busy        controller is not idle, driven by slave
//   frame_done  one-cycle end-of-frame pulse, driven by slave
interface conv_window_ctrl_if #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          lb_wr_en;
    logic [CW-1:0] lb_addr;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, lb_wr_en, lb_addr, out_valid, out_row, out_col, busy, frame_done
    );

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, lb_wr_en, lb_addr, out_valid, out_row, out_col, busy, frame_done
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-scan controller for a 3x3 convolution window.
// Counts incoming pixels (row/col), strobes the line buffer on every accepted
// pixel and announces a complete window (centre coordinates) once the pixel at
// row>=2, col>=2 has been accepted. Border pixels never produce windows.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    conv_window_ctrl_if.slave (start / pixel-in / window-out handshakes, status)
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_ctrl_if.slave bus
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_out_valid;
    logic [RW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic          r_frame_done;

    logic w_active;
    logic w_in_ready;
    logic w_accept;
    logic w_window;
    logic w_last_pixel;
    logic w_start_take;
    logic w_consume;

    assign w_active     = (r_state == S_FILL) || (r_state == S_RUN);
    // A pixel may only enter when the output slot is free or being emptied,
    // so a freshly produced window can never overwrite an unconsumed one.
    assign w_in_ready   = w_active && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_window     = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_last_pixel = (r_row == ROW_LAST) && (r_col == COL_LAST);
    // A start coinciding with frame_done is dropped: the controller must be
    // seen idle for a full cycle before a new frame begins.
    assign w_start_take = (r_state == S_IDLE) && bus.start && !r_frame_done;
    assign w_consume    = r_out_valid && bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_take) w_state_next = S_FILL;
                else              w_state_next = S_IDLE;
            end
            S_FILL: begin
                if (w_accept && w_last_pixel) w_state_next = S_DONE;
                else if (w_window)            w_state_next = S_RUN;
                else                          w_state_next = S_FILL;
            end
            S_RUN: begin
                if (w_accept && w_last_pixel) w_state_next = S_DONE;
                else                          w_state_next = S_RUN;
            end
            S_DONE: begin
                // Leave only once the final window has drained.
                if (!r_out_valid || bus.out_ready) w_state_next = S_IDLE;
                else                               w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Raster position counters; frozen on the final pixel so DONE holds the last position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start_take) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept && !w_last_pixel) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + ROW_ONE;
            end else begin
                r_col <= r_col + COL_ONE;
            end
        end
    end

    // Window output slot and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_window) begin
                // Window centre lags the newest pixel by one row and one column.
                r_out_valid <= 1'b1;
                r_out_row   <= r_row - ROW_ONE;
                r_out_col   <= r_col - COL_ONE;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            r_frame_done <= (r_state == S_DONE) && (w_state_next == S_IDLE);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.lb_wr_en   = w_accept;
    assign bus.lb_addr    = r_col;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_row    = r_out_row;
    assign bus.out_col    = r_out_col;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Testbench for conv_window_ctrl with an 8x6 image.
// A monitor process keeps a reference model of the controller, pushes the
// expected window coordinates into a scoreboard queue on every accepted pixel
// and pops/compares them whenever the DUT hands a window downstream.
module tb_conv_window_ctrl;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    typedef struct {
        int r;
        int c;
    } win_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_window_ctrl_if #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) bus ();

    conv_window_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;

    // reference model
    bit   m_active, m_done, m_ov, m_fd;
    int   m_row, m_col;
    win_t sb[$];

    // per-test statistics gathered from observed DUT activity
    int   st_acc, st_win, st_fd;
    int   st_first_r, st_first_c, st_last_r, st_last_c;
    bit   st_seen;

    // Cycle monitor: samples on the falling edge, checks, then advances the model.
    initial begin : monitor
        bit   exp_ir, acc, cons, was_idle, next_fd;
        win_t w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_active = 1'b0; m_done = 1'b0; m_ov = 1'b0; m_fd = 1'b0;
                m_row = 0; m_col = 0;
                sb.delete();
            end else begin
                exp_ir = m_active && (!m_ov || bus.out_ready);
                acc    = bus.in_valid && exp_ir;
                cons   = m_ov && bus.out_ready;
                n_vec++;
                if (bus.in_ready !== exp_ir) begin
                    n_err++; $display("FAIL in_ready @%0t: got %b want %b", $time, bus.in_ready, exp_ir);
                end
                n_vec++;
                if (bus.lb_wr_en !== acc) begin
                    n_err++; $display("FAIL lb_wr_en @%0t: got %b want %b", $time, bus.lb_wr_en, acc);
                end
                n_vec++;
                if (bus.out_valid !== m_ov) begin
                    n_err++; $display("FAIL out_valid @%0t: got %b want %b", $time, bus.out_valid, m_ov);
                end
                n_vec++;
                if (bus.busy !== (m_active || m_done)) begin
                    n_err++; $display("FAIL busy @%0t: got %b want %b", $time, bus.busy, m_active || m_done);
                end
                n_vec++;
                if (bus.frame_done !== m_fd) begin
                    n_err++; $display("FAIL frame_done @%0t: got %b want %b", $time, bus.frame_done, m_fd);
                end
                if (acc) begin
                    st_acc++;
                    n_vec++;
                    if (bus.lb_addr !== CW'(m_col)) begin
                        n_err++; $display("FAIL lb_addr @%0t: got %0d want %0d", $time, bus.lb_addr, m_col);
                    end
                end
                if (bus.frame_done === 1'b1) st_fd++;
                if (cons) begin
                    st_win++;
                    if (!st_seen) begin
                        st_seen = 1'b1; st_first_r = int'(bus.out_row); st_first_c = int'(bus.out_col);
                    end
                    st_last_r = int'(bus.out_row); st_last_c = int'(bus.out_col);
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++; $display("FAIL window_extra @%0t: got (%0d,%0d) want none", $time, bus.out_row, bus.out_col);
                    end else begin
                        w = sb.pop_front();
                        if (bus.out_row !== RW'(w.r) || bus.out_col !== CW'(w.c)) begin
                            n_err++; $display("FAIL window_coord @%0t: got (%0d,%0d) want (%0d,%0d)", $time, bus.out_row, bus.out_col, w.r, w.c);
                        end
                    end
                end
                // advance the model to the state after the coming rising edge
                was_idle = !m_active && !m_done;
                next_fd  = 1'b0;
                if (m_done && (!m_ov || bus.out_ready)) begin
                    m_done = 1'b0; next_fd = 1'b1;
                end
                if (acc && m_row >= 2 && m_col >= 2) begin
                    sb.push_back('{r: m_row - 1, c: m_col - 1});
                    m_ov = 1'b1;
                end else if (cons) begin
                    m_ov = 1'b0;
                end
                if (acc) begin
                    if (m_row == H - 1 && m_col == W - 1) begin
                        m_active = 1'b0; m_done = 1'b1;
                    end else if (m_col == W - 1) begin
                        m_col = 0; m_row++;
                    end else begin
                        m_col++;
                    end
                end
                if (was_idle && bus.start && !m_fd) begin
                    m_active = 1'b1; m_row = 0; m_col = 0;
                end
                m_fd = next_fd;
            end
        end
    end

    task automatic clear_stats();
        st_acc = 0; st_win = 0; st_fd = 0; st_seen = 1'b0;
        st_first_r = -1; st_first_c = -1; st_last_r = -1; st_last_c = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2; bus.start = 1'b1;
        @(posedge clk); #2; bus.start = 1'b0;
    endtask

    // Drives the pixel/window handshakes until frame_done is seen; returns at posedge+1 of that cycle.
    task automatic run_to_done(input bit rnd, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            #1;
            bus.in_valid  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #23;
        n_vec++;
        if ({bus.in_ready, bus.lb_wr_en, bus.out_valid, bus.busy, bus.frame_done} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {bus.in_ready, bus.lb_wr_en, bus.out_valid, bus.busy, bus.frame_done});
        end
        n_vec++;
        if (bus.out_row !== RW'(0) || bus.out_col !== CW'(0) || bus.lb_addr !== CW'(0)) begin
            n_err++; $display("FAIL reset_coords: got row %0d col %0d addr %0d want 0", bus.out_row, bus.out_col, bus.lb_addr);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: busy %b want 0", bus.busy);
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        clear_stats();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        pulse_start();
        run_to_done(1'b0, 200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL full_timeout: frame_done not seen want seen"); end
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL full_busy_at_done: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        n_vec++;
        if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL full_done_width: got %b want 0", bus.frame_done); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (st_acc != 48) begin n_err++; $display("FAIL full_accepts: got %0d want 48", st_acc); end
        n_vec++;
        if (st_win != 24) begin n_err++; $display("FAIL full_windows: got %0d want 24", st_win); end
        n_vec++;
        if (st_first_r != 1 || st_first_c != 1) begin
            n_err++; $display("FAIL full_first: got (%0d,%0d) want (1,1)", st_first_r, st_first_c);
        end
        n_vec++;
        if (st_last_r != 4 || st_last_c != 6) begin
            n_err++; $display("FAIL full_last: got (%0d,%0d) want (4,6)", st_last_r, st_last_c);
        end
        n_vec++;
        if (st_fd != 1) begin n_err++; $display("FAIL full_done_count: got %0d want 1", st_fd); end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL full_scoreboard: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [RW-1:0] hold_r;
        logic [CW-1:0] hold_c;
        clear_stats();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL bp_timeout: out_valid not seen want seen"); end
        #1; bus.out_ready = 1'b0;
        hold_r = bus.out_row; hold_c = bus.out_col;
        repeat (5) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_row !== hold_r || bus.out_col !== hold_c) begin
                n_err++; $display("FAIL bp_hold: got v%b (%0d,%0d) want v1 (%0d,%0d)", bus.out_valid, bus.out_row, bus.out_col, hold_r, hold_c);
            end
            n_vec++;
            if (bus.in_ready !== 1'b0 || bus.lb_wr_en !== 1'b0) begin
                n_err++; $display("FAIL bp_stall: got ready %b wr %b want 0 0", bus.in_ready, bus.lb_wr_en);
            end
        end
        #1; bus.out_ready = 1'b1;
        run_to_done(1'b0, 200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL bp_done_timeout: frame_done not seen want seen"); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (st_win != 24 || st_acc != 48) begin
            n_err++; $display("FAIL bp_counts: got %0d windows %0d accepts want 24 48", st_win, st_acc);
        end
    endtask

    task automatic test_random_gaps();
        bit ok;
        clear_stats();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        pulse_start();
        run_to_done(1'b1, 2000, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL rnd_timeout: frame_done not seen want seen"); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (st_win != 24 || st_acc != 48) begin
            n_err++; $display("FAIL rnd_counts: got %0d windows %0d accepts want 24 48", st_win, st_acc);
        end
        n_vec++;
        if (st_first_r != 1 || st_first_c != 1 || st_last_r != 4 || st_last_c != 6) begin
            n_err++; $display("FAIL rnd_ends: got (%0d,%0d)..(%0d,%0d) want (1,1)..(4,6)", st_first_r, st_first_c, st_last_r, st_last_c);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        clear_stats();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (m_row == 3 && m_col == 4) begin ok = 1'b1; break; end
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL mid_timeout: row 3 col 4 not reached want reached"); end
        #2; rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.in_ready, bus.lb_wr_en, bus.out_valid, bus.busy, bus.frame_done} !== 5'b0) begin
            n_err++; $display("FAIL mid_reset_flags: got %b want 00000", {bus.in_ready, bus.lb_wr_en, bus.out_valid, bus.busy, bus.frame_done});
        end
        n_vec++;
        if (bus.out_row !== RW'(0) || bus.out_col !== CW'(0) || bus.lb_addr !== CW'(0)) begin
            n_err++; $display("FAIL mid_reset_coords: got row %0d col %0d addr %0d want 0", bus.out_row, bus.out_col, bus.lb_addr);
        end
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.busy !== 1'b0 || bus.lb_wr_en !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_err++; $display("FAIL mid_quiet: got busy %b wr %b ov %b want 0 0 0", bus.busy, bus.lb_wr_en, bus.out_valid);
            end
        end
        clear_stats();
        pulse_start();
        run_to_done(1'b0, 200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL mid_done_timeout: frame_done not seen want seen"); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (st_win != 24 || st_acc != 48 || st_first_r != 1 || st_first_c != 1) begin
            n_err++; $display("FAIL mid_refill: got %0d win %0d acc first (%0d,%0d) want 24 48 (1,1)", st_win, st_acc, st_first_r, st_first_c);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_stats();
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (st_acc != 0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL idle_no_accept: got %0d accepts busy %b want 0 0", st_acc, bus.busy);
        end
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (st_acc >= 24) begin ok = 1'b1; break; end
        end
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL si_mid_timeout: midpoint not reached want reached"); end
        #1; bus.start = 1'b1;
        @(posedge clk); #2; bus.start = 1'b0;
        run_to_done(1'b0, 200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL si_done_timeout: frame_done not seen want seen"); end
        #1; bus.start = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL start_on_done: busy %b want 0", bus.busy); end
        #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (st_win != 24 || st_acc != 48 || st_fd != 1) begin
            n_err++; $display("FAIL si_counts: got %0d win %0d acc %0d done want 24 48 1", st_win, st_acc, st_fd);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_full_frame();
        test_backpressure();
        test_random_gaps();
        test_reset_midframe();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter IMAGE_WIDTH, default 512, pixels per row (>=3).
REQ-002 Parameter IMAGE_HEIGHT, default 512, rows per frame (>=3).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  frame start request, single-cycle pulse.
REQ-006 in_valid  input  1  upstream pixel available.
REQ-007 in_ready  output  1  controller accepts pixel this cycle.
REQ-008 lb_wr_en  output  1  line-buffer write/shift strobe, equals accept.
REQ-009 lb_addr  output  $clog2(IMAGE_WIDTH)  line-buffer column address, equals current col.
REQ-010 out_valid  output  1  3x3 window complete; downstream kernel (gaussian/sobel) may fire.
REQ-011 out_ready  input  1  downstream consumes window.
REQ-012 out_row  output  $clog2(IMAGE_HEIGHT)  window centre row.
REQ-013 out_col  output  $clog2(IMAGE_WIDTH)  window centre column.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 States IDLE, FILL, RUN, DONE; encoding free.
REQ-017 IDLE -> FILL on start; row and col counters cleared to 0 on that edge.
REQ-018 accept = in_valid && in_ready; in_ready = (state is FILL or RUN) && (!out_valid || out_ready), combinational.
REQ-019 On accept: col increments; at col == IMAGE_WIDTH-1 col wraps to 0 and row increments.
REQ-020 Accept of pixel at row>=2 and col>=2 produces a window: next edge out_valid=1, out_row=row-1, out_col=col-1.
REQ-021 FILL -> RUN on first window-producing accept (row 2, col 2).
REQ-022 Accept of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) -> DONE; counters not advanced further; in_ready=0 in DONE.
REQ-023 out_valid, out_row, out_col held stable while out_valid && !out_ready.
REQ-024 out_valid cleared on out_ready unless a new window is produced the same edge, in which case new coordinates load and out_valid stays 1.
REQ-025 DONE -> IDLE once out_valid is 0 or being consumed this cycle; frame_done pulses 1 cycle coincident with entering IDLE.
REQ-026 Exactly (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) windows per frame, in raster order; no windows for border pixels.
REQ-027 start ignored when busy=1; start and frame_done in same cycle: start not taken (returns to IDLE first).
REQ-028 in_valid while IDLE or DONE: no accept, no counter change.
REQ-029 Pixels beyond frame end never accepted; no extra window or counter wrap.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE, row=0, col=0, out_valid=0, out_row=0, out_col=0, frame_done=0, busy=0; in_ready and lb_wr_en therefore 0.
REQ-031 Reset mid-frame discards partial frame; after release, no output until new start.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=6)
REQ-032 start, in_valid=1, out_ready=1 continuously -> 48 accepts, 24 windows, first at (1,1), last at (4,6), frame_done once, busy falls same cycle.
REQ-033 out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_row/out_col unchanged, no accept; resume with no window lost or duplicated.
REQ-034 Random in_valid and out_ready gaps -> window sequence identical to REQ-032, lb_addr follows 0..7 wrap per row.
REQ-035 rst_n low at row 3 col 4 -> all outputs at reset values immediately; new start gives full 24-window frame from (1,1).
REQ-036 start pulsed at frame midpoint and start with in_valid while IDLE -> mid-frame start ignored; no accept before start taken.
